// File: rtl/csc_ycocg_pipe.sv
// Two-stage pipelined RGB <-> YCoCg-R converter, PPC independent lanes per beat.
// Optional: define CSC_CLIP_CNT_EN to add a saturating count of clipped inverse components.
module csc_ycocg_pipe #(
  parameter int BPC = 8,
  parameter int PPC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef CSC_CLIP_CNT_EN
  input  logic                   clip_clr,
  output logic [15:0]            clip_cnt,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [PPC*(BPC+1)-1:0] in_c0,
  input  logic [PPC*(BPC+1)-1:0] in_c1,
  input  logic [PPC*(BPC+1)-1:0] in_c2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_mode,
  output logic [PPC*(BPC+1)-1:0] out_c0,
  output logic [PPC*(BPC+1)-1:0] out_c1,
  output logic [PPC*(BPC+1)-1:0] out_c2
);
  localparam int LW = BPC + 1;
  localparam int SW = BPC + 2;
  // S2 works one bit wider so an out-of-range inverse result keeps its true sign for clipping.
  localparam int XW = BPC + 3;

  // Valid/ready: a beat moves when valid && ready on that edge; a stage accepts when it is
  // empty or its content leaves in the same cycle, and a stalled output holds steady.
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_mode_q, s2_mode_q;
  logic s1_adv, s2_adv, in_fire, s2_load;

  logic [PPC-1:0][SW-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q, s1_c_d, s1_c_q;
  logic [PPC*LW-1:0]      s2_c0_d, s2_c0_q, s2_c1_d, s2_c1_q, s2_c2_d, s2_c2_q;

  assign s2_adv     = !s2_valid_q || out_ready;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready   = s1_adv;
  assign in_fire    = in_valid && s1_adv;
  assign s2_load    = s1_valid_q && s2_adv;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  function automatic logic [BPC-1:0] clip(input logic [XW-1:0] v);
    if (v[XW-1]) return '0;
    if (|v[XW-2:BPC]) return '1;
    return v[BPC-1:0];
  endfunction

  // S1 keeps (t, Co, Cg) for inverse beats and (Co, t, G) for forward beats.
  for (genvar p = 0; p < PPC; p++) begin : g_s1
    logic signed [SW-1:0] c0z, c1z, c2z, c1s, c2s, t_inv, co_fwd, t_fwd;
    logic unused_msb;
    assign unused_msb = in_c0[p*LW+BPC];
    assign c0z    = SW'(in_c0[p*LW +: BPC]);
    assign c1z    = SW'(in_c1[p*LW +: BPC]);
    assign c2z    = SW'(in_c2[p*LW +: BPC]);
    assign c1s    = SW'($signed(in_c1[p*LW +: LW]));
    assign c2s    = SW'($signed(in_c2[p*LW +: LW]));
    assign t_inv  = c0z - (c2s >>> 1);
    assign co_fwd = c0z - c2z;
    assign t_fwd  = c2z + (co_fwd >>> 1);
    assign s1_a_d[p] = in_mode ? co_fwd : t_inv;
    assign s1_b_d[p] = in_mode ? t_fwd  : c1s;
    assign s1_c_d[p] = in_mode ? c1z    : c2s;
  end

`ifdef CSC_CLIP_CNT_EN
  localparam int NCW = $clog2(3*PPC+1);
  logic [PPC-1:0][1:0] lane_clips;
  logic [NCW-1:0]      s2_nclip_d, s2_nclip_q;
  logic [15:0]         clip_cnt_q;
  logic [16:0]         clip_sum;

  function automatic logic clipped(input logic [XW-1:0] v);
    return v[XW-1] | (|v[XW-2:BPC]);
  endfunction
`endif

  for (genvar p = 0; p < PPC; p++) begin : g_s2
    logic signed [XW-1:0] a, b, c, g_inv, b_inv, r_inv, cg_fwd, y_fwd;
    logic unused_hi;
    assign a      = XW'($signed(s1_a_q[p]));
    assign b      = XW'($signed(s1_b_q[p]));
    assign c      = XW'($signed(s1_c_q[p]));
    assign g_inv  = c + a;
    assign b_inv  = a - (b >>> 1);
    assign r_inv  = b_inv + b;
    assign cg_fwd = c - b;
    assign y_fwd  = b + (cg_fwd >>> 1);
    assign unused_hi = ^y_fwd[XW-1:BPC];
    assign s2_c0_d[p*LW +: LW] = s1_mode_q ? {1'b0, y_fwd[BPC-1:0]} : {1'b0, clip(r_inv)};
    assign s2_c1_d[p*LW +: LW] = s1_mode_q ? a[LW-1:0]               : {1'b0, clip(g_inv)};
    assign s2_c2_d[p*LW +: LW] = s1_mode_q ? cg_fwd[LW-1:0]          : {1'b0, clip(b_inv)};
`ifdef CSC_CLIP_CNT_EN
    assign lane_clips[p] = s1_mode_q ? 2'd0
                         : 2'(clipped(r_inv)) + 2'(clipped(g_inv)) + 2'(clipped(b_inv));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s2_mode_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s2_c0_q    <= '0;
      s2_c1_q    <= '0;
      s2_c2_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_mode_q <= in_mode;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_c_q    <= s1_c_d;
      end
      if (s2_load) begin
        s2_mode_q <= s1_mode_q;
        s2_c0_q   <= s2_c0_d;
        s2_c1_q   <= s2_c1_d;
        s2_c2_q   <= s2_c2_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mode  = s2_mode_q;
  assign out_c0    = s2_c0_q;
  assign out_c1    = s2_c1_q;
  assign out_c2    = s2_c2_q;

`ifdef CSC_CLIP_CNT_EN
  always_comb begin
    s2_nclip_d = '0;
    for (int p = 0; p < PPC; p++) s2_nclip_d = s2_nclip_d + NCW'(lane_clips[p]);
  end

  assign clip_sum = {1'b0, clip_cnt_q} + 17'(s2_nclip_q);

  // The per-beat clip tally rides in S2 and is only added when that beat leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_nclip_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      if (s2_load) s2_nclip_q <= s2_nclip_d;
      if (clip_clr) clip_cnt_q <= '0;
      else if (s2_valid_q && out_ready) clip_cnt_q <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif
endmodule

// File: tb/tb_csc_ycocg_pipe.sv
// Scoreboard bench for csc_ycocg_pipe: a PPC=1 instance with directed vectors and a PPC=4
// instance with table-built beats under random backpressure, plus a mid-flight reset.
module tb_csc_ycocg_pipe;
  localparam int BPC = 8;
  localparam int LW  = BPC + 1;
  localparam int W1  = 1 + 3*LW;
  localparam int W4  = 1 + 3*4*LW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid1 = 1'b0, in_mode1 = 1'b0, out_ready1 = 1'b1;
  logic          in_ready1, out_valid1, out_mode1;
  logic [LW-1:0] in_c0_1 = '0, in_c1_1 = '0, in_c2_1 = '0;
  logic [LW-1:0] out_c0_1, out_c1_1, out_c2_1;

  logic            in_valid4 = 1'b0, in_mode4 = 1'b0, out_ready4 = 1'b1;
  logic            in_ready4, out_valid4, out_mode4;
  logic [4*LW-1:0] in_c0_4 = '0, in_c1_4 = '0, in_c2_4 = '0;
  logic [4*LW-1:0] out_c0_4, out_c1_4, out_c2_4;

`ifdef CSC_CLIP_CNT_EN
  logic        clip_clr1 = 1'b0;
  logic [15:0] clip_cnt1, clip_cnt4;
`endif

  csc_ycocg_pipe #(.BPC(BPC), .PPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef CSC_CLIP_CNT_EN
    .clip_clr(clip_clr1), .clip_cnt(clip_cnt1),
`endif
    .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1),
    .in_c0(in_c0_1), .in_c1(in_c1_1), .in_c2(in_c2_1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_mode(out_mode1),
    .out_c0(out_c0_1), .out_c1(out_c1_1), .out_c2(out_c2_1)
  );

  csc_ycocg_pipe #(.BPC(BPC), .PPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef CSC_CLIP_CNT_EN
    .clip_clr(1'b0), .clip_cnt(clip_cnt4),
`endif
    .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4),
    .in_c0(in_c0_4), .in_c1(in_c1_4), .in_c2(in_c2_4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_mode(out_mode4),
    .out_c0(out_c0_4), .out_c1(out_c1_4), .out_c2(out_c2_4)
  );

  // Hand-computed vectors: {c0,c1,c2} in -> {c0,c1,c2} out.
  logic [LW-1:0] inv_in [5][3] = '{'{9'h080, 9'h000, 9'h000}, '{9'h0FF, 9'h0FF, 9'h000},
                                   '{9'h000, 9'h000, 9'h0FE}, '{9'h03F, 9'h0FF, 9'h181},
                                   '{9'h180, 9'h000, 9'h000}};
  logic [LW-1:0] inv_exp[5][3] = '{'{9'h080, 9'h080, 9'h080}, '{9'h0FF, 9'h0FF, 9'h080},
                                   '{9'h000, 9'h07F, 9'h000}, '{9'h0FF, 9'h000, 9'h000},
                                   '{9'h080, 9'h080, 9'h080}};
  logic [LW-1:0] fwd_in [5][3] = '{'{9'h0FF, 9'h000, 9'h000}, '{9'h000, 9'h000, 9'h000},
                                   '{9'h0FF, 9'h0FF, 9'h0FF}, '{9'h000, 9'h0FF, 9'h000},
                                   '{9'h1FF, 9'h100, 9'h100}};
  logic [LW-1:0] fwd_exp[5][3] = '{'{9'h03F, 9'h0FF, 9'h181}, '{9'h000, 9'h000, 9'h000},
                                   '{9'h0FF, 9'h000, 9'h000}, '{9'h07F, 9'h000, 9'h0FF},
                                   '{9'h03F, 9'h0FF, 9'h181}};

  // scoreboard
  logic [W1-1:0] exp1_q[$];
  logic [W4-1:0] exp4_q[$];
  int            lat1_q[$];
  int            checks = 0, errors = 0;
  int            acc4 = 0, pop4 = 0;
  logic          rand_en = 1'b0;
  logic          prev_stall4 = 1'b0;
  logic [W4-1:0] held4 = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no handshake expected one", name);
  endtask

  // drivers
  task automatic send1(input logic m, input int k);
    logic hs;
    int   n, acc_cyc;
    in_valid1 = 1'b1;
    in_mode1  = m;
    in_c0_1   = m ? fwd_in[k][0] : inv_in[k][0];
    in_c1_1   = m ? fwd_in[k][1] : inv_in[k][1];
    in_c2_1   = m ? fwd_in[k][2] : inv_in[k][2];
    hs = 1'b0; n = 0; acc_cyc = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready1;
      acc_cyc = cyc;
      @(posedge clk);
      n++;
    end
    if (hs) begin
      if (m) exp1_q.push_back({m, fwd_exp[k][0], fwd_exp[k][1], fwd_exp[k][2]});
      else   exp1_q.push_back({m, inv_exp[k][0], inv_exp[k][1], inv_exp[k][2]});
      lat1_q.push_back(acc_cyc);
    end else timeout("dut1_in_handshake");
    #1;
  endtask

  task automatic send4(input int i);
    logic            m, hs;
    int              n, k;
    logic [4*LW-1:0] c0, c1, c2, e0, e1, e2;
    m = i[0];
    for (int p = 0; p < 4; p++) begin
      k = (i + p) % 5;
      c0[p*LW +: LW] = m ? fwd_in[k][0]  : inv_in[k][0];
      c1[p*LW +: LW] = m ? fwd_in[k][1]  : inv_in[k][1];
      c2[p*LW +: LW] = m ? fwd_in[k][2]  : inv_in[k][2];
      e0[p*LW +: LW] = m ? fwd_exp[k][0] : inv_exp[k][0];
      e1[p*LW +: LW] = m ? fwd_exp[k][1] : inv_exp[k][1];
      e2[p*LW +: LW] = m ? fwd_exp[k][2] : inv_exp[k][2];
    end
    in_valid4 = 1'b1; in_mode4 = m; in_c0_4 = c0; in_c1_4 = c1; in_c2_4 = c2;
    hs = 1'b0; n = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready4;
      @(posedge clk);
      n++;
    end
    if (hs) begin
      exp4_q.push_back({m, e0, e1, e2});
      acc4++;
    end else timeout("dut4_in_handshake");
    #1;
  endtask

  task automatic wait_drain1();
    int n = 0;
    while (exp1_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check("dut1_drain", 128'(exp1_q.size()), 128'(0));
    #1;
  endtask

  task automatic wait_drain4();
    int n = 0;
    while (exp4_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    check("dut4_drain", 128'(exp4_q.size()), 128'(0));
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_en) out_ready4 = ($urandom_range(0, 3) != 0);
  end

  // monitors
  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected: got beat %h expected none", {out_mode1, out_c0_1, out_c1_1, out_c2_1});
      end else begin
        check("dut1_beat", 128'({out_mode1, out_c0_1, out_c1_1, out_c2_1}), 128'(exp1_q.pop_front()));
        check("dut1_latency", 128'(cyc - lat1_q.pop_front()), 128'(2));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall4 = 1'b0;
    else begin
      if (prev_stall4)
        check("dut4_stall_hold", 128'({out_valid4, out_mode4, out_c0_4, out_c1_4, out_c2_4}),
              128'({1'b1, held4}));
      check("dut4_in_ready", 128'(in_ready4), 128'(!((acc4 - pop4) == 2 && !out_ready4)));
      if (out_valid4 && out_ready4) begin
        pop4++;
        if (exp4_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut4_unexpected: got beat %h expected none", {out_mode4, out_c0_4, out_c1_4, out_c2_4});
        end else
          check("dut4_beat", 128'({out_mode4, out_c0_4, out_c1_4, out_c2_4}), 128'(exp4_q.pop_front()));
      end
      prev_stall4 = out_valid4 && !out_ready4;
      held4 = {out_mode4, out_c0_4, out_c1_4, out_c2_4};
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid1", 128'(out_valid1), 128'(0));
    check("rst_out_mode1",  128'(out_mode1),  128'(0));
    check("rst_out_data1",  128'({out_c0_1, out_c1_1, out_c2_1}), 128'(0));
    check("rst_in_ready1",  128'(in_ready1),  128'(1));
    check("rst_out_valid4", 128'(out_valid4), 128'(0));
    check("rst_out_data4",  128'({out_mode4, out_c0_4, out_c1_4, out_c2_4}), 128'(0));
    @(posedge clk); #1;

    // PPC=1 directed: clip case first, then a mixed-mode back-to-back stream.
    send1(1'b0, 2);
    in_valid1 = 1'b0;
    wait_drain1();
`ifdef CSC_CLIP_CNT_EN
    @(negedge clk);
    check("clip_cnt_after_clip", 128'(clip_cnt1), 128'(2));
    @(posedge clk); #1 clip_clr1 = 1'b1;
    @(posedge clk); #1 clip_clr1 = 1'b0;
    @(negedge clk);
    check("clip_cnt_cleared", 128'(clip_cnt1), 128'(0));
    @(posedge clk); #1;
`endif
    send1(1'b0, 0);
    send1(1'b0, 1);
    send1(1'b1, 0);
    send1(1'b0, 3);
    send1(1'b1, 1);
    send1(1'b0, 4);
    send1(1'b1, 2);
    send1(1'b1, 3);
    send1(1'b1, 4);
    in_valid1 = 1'b0;
    wait_drain1();

    // PPC=4: alternating modes under random backpressure, then an ignored junk cycle.
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++) send4(i);
    in_valid4 = 1'b0;
    in_c0_4 = '1; in_c1_4 = '1; in_c2_4 = '1; in_mode4 = 1'b1;
    wait_drain4();
    rand_en = 1'b0;
    out_ready4 = 1'b0;

    // Fill both stages, then reset mid-flight.
    send4(3);
    send4(4);
    in_valid4 = 1'b0;
    @(negedge clk);
    check("full_in_ready4",  128'(in_ready4),  128'(0));
    check("full_out_valid4", 128'(out_valid4), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp4_q.delete();
    acc4 = 0; pop4 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid4", 128'(out_valid4), 128'(0));
    check("post_rst_in_ready4",  128'(in_ready4),  128'(1));
    check("post_rst_data4", 128'({out_mode4, out_c0_4, out_c1_4, out_c2_4}), 128'(0));
    @(posedge clk); #1 out_ready4 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final_queue4", 128'(exp4_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
